// File: rtl/oc_collector_param.sv
`default_nettype none
// ============================================================================
// Module   : oc_collector_param
// Brief    : Operand collector unit. Issues one bank read per needed source,
//            captures tagged bank returns, then dispatches operands + payload.
// Revision : 1.0 - initial release
// ============================================================================
module oc_collector_param #(
    parameter int OCID      = 0,
    parameter int NUM_SRC   = 3,
    parameter int NUM_BANKS = 4,
    parameter int DATA_W    = 256,
    parameter int REG_ID_W  = 5,
    parameter int TAG_W     = 4,
    parameter int PYLD_W    = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         alloc_vld,
    output logic                         alloc_rdy,
    input  logic [NUM_SRC-1:0]           alloc_src_mask,
    input  logic [NUM_SRC*REG_ID_W-1:0]  alloc_reg_id,
    input  logic [PYLD_W-1:0]            alloc_pyld,
    output logic                         rq_vld,
    input  logic                         rq_rdy,
    output logic [REG_ID_W-1:0]          rq_reg_id,
    output logic [TAG_W-1:0]             rq_tag,
    input  logic [NUM_BANKS-1:0]         bk_vld,
    input  logic [NUM_BANKS-1:0]         bk_bz,
    input  logic [NUM_BANKS*TAG_W-1:0]   bk_tag,
    input  logic [NUM_BANKS*DATA_W-1:0]  bk_data,
    output logic                         out_vld,
    input  logic                         out_rdy,
    output logic [NUM_SRC*DATA_W-1:0]    out_data,
    output logic [PYLD_W-1:0]            out_pyld
);

    localparam int c_BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    generate
        if ((OCID * NUM_SRC + NUM_SRC - 1) >= (2 ** TAG_W)) begin : g_tag_check
            $error("oc_collector_param: slot tags of OCID %0d do not fit in TAG_W %0d", OCID, TAG_W);
        end
        if (NUM_SRC < 1 || NUM_SRC > 8) begin : g_src_check
            $error("oc_collector_param: NUM_SRC %0d outside 1..8", NUM_SRC);
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        READY   = 2'd2
    } state_t;

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [NUM_SRC-1:0]            r_need;
    logic [NUM_SRC-1:0]            r_req_done;
    logic [NUM_SRC-1:0]            r_got;
    logic [NUM_SRC*REG_ID_W-1:0]   r_reg_id;
    logic [NUM_SRC*DATA_W-1:0]     r_data;
    logic [PYLD_W-1:0]             r_pyld;

    logic [NUM_SRC-1:0]            w_pend;
    logic [NUM_SRC-1:0]            w_grant;
    logic [NUM_SRC-1:0]            w_cap;
    logic [NUM_SRC*DATA_W-1:0]     w_cap_data;
    logic                          w_alloc;
    logic                          w_done_all;
    logic                          w_collect;

    assign w_collect  = (r_state == COLLECT);
    assign alloc_rdy  = (r_state == IDLE);
    assign out_vld    = (r_state == READY);
    assign out_data   = r_data;
    assign out_pyld   = r_pyld;
    assign w_alloc    = alloc_vld & alloc_rdy & ~flush;
    assign w_pend     = r_need & ~r_req_done;
    assign w_done_all = &(r_got | w_cap | ~r_need);

    // Lowest pending slot wins; descending scan leaves the lowest index last.
    always_comb begin
        rq_vld    = 1'b0;
        rq_reg_id = '0;
        rq_tag    = '0;
        w_grant   = '0;
        for (int s = NUM_SRC - 1; s >= 0; s--) begin
            if (w_collect && w_pend[s]) begin
                rq_vld    = 1'b1;
                rq_reg_id = r_reg_id[s*REG_ID_W +: REG_ID_W];
                rq_tag    = TAG_W'(OCID * NUM_SRC + s);
                w_grant   = '0;
                w_grant[s] = 1'b1;
            end
        end
    end

    genvar gs;
    generate
        for (gs = 0; gs < NUM_SRC; gs++) begin : g_slot
            localparam logic [TAG_W-1:0] c_TAG = TAG_W'(OCID * NUM_SRC + gs);
            logic [c_BANK_W-1:0] w_bank;
            logic                w_hit;
            logic [DATA_W-1:0]   w_sel;

            if (NUM_BANKS > 1) begin : g_bank_sel
                assign w_bank = r_reg_id[gs*REG_ID_W + REG_ID_W - 1 -: c_BANK_W];
            end else begin : g_bank_one
                assign w_bank = '0;
            end

            always_comb begin
                w_hit = 1'b0;
                w_sel = '0;
                for (int k = 0; k < NUM_BANKS; k++) begin
                    if (w_bank == c_BANK_W'(k)) begin
                        w_hit = bk_vld[k] & ~bk_bz[k] & (bk_tag[k*TAG_W +: TAG_W] == c_TAG);
                        w_sel = bk_data[k*DATA_W +: DATA_W];
                    end
                end
            end

            assign w_cap[gs] = w_hit & r_req_done[gs] & ~r_got[gs] & w_collect;
            assign w_cap_data[gs*DATA_W +: DATA_W] = w_sel;
        end
    endgenerate

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_alloc) w_state_nxt = (alloc_src_mask == '0) ? READY : COLLECT;
            COLLECT: if (w_done_all) w_state_nxt = READY;
            READY:   if (out_rdy) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (flush) w_state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_need     <= '0;
            r_req_done <= '0;
            r_got      <= '0;
            r_reg_id   <= '0;
            r_data     <= '0;
            r_pyld     <= '0;
        end else if (flush) begin
            // Operands and payload keep their last values; only tracking is dropped.
            r_state    <= IDLE;
            r_need     <= '0;
            r_req_done <= '0;
            r_got      <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_alloc) begin
                r_need     <= alloc_src_mask;
                r_req_done <= '0;
                r_got      <= '0;
                r_reg_id   <= alloc_reg_id;
                r_pyld     <= alloc_pyld;
                r_data     <= '0;
            end else if (w_collect) begin
                r_req_done <= r_req_done | (w_grant & {NUM_SRC{rq_rdy}});
                r_got      <= r_got | w_cap;
                for (int s = 0; s < NUM_SRC; s++) begin
                    if (w_cap[s]) r_data[s*DATA_W +: DATA_W] <= w_cap_data[s*DATA_W +: DATA_W];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_oc_collector_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_oc_collector_param
// Brief    : Directed self-checking bench for oc_collector_param (OCID=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_oc_collector_param;

    localparam int OCID = 1, NS = 3, NB = 4, DW = 256, RW = 5, TW = 4, PW = 64;

    logic              clk = 1'b0;
    logic              rst, flush, alloc_vld, alloc_rdy;
    logic [NS-1:0]     alloc_src_mask;
    logic [NS*RW-1:0]  alloc_reg_id;
    logic [PW-1:0]     alloc_pyld;
    logic              rq_vld, rq_rdy;
    logic [RW-1:0]     rq_reg_id;
    logic [TW-1:0]     rq_tag;
    logic [NB-1:0]     bk_vld, bk_bz;
    logic [NB*TW-1:0]  bk_tag;
    logic [NB*DW-1:0]  bk_data;
    logic              out_vld, out_rdy;
    logic [NS*DW-1:0]  out_data;
    logic [PW-1:0]     out_pyld;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] d0, d1, d2, d3, d4, d5, d6, zero;
    logic [PW-1:0] p1, p2;

    oc_collector_param #(
        .OCID(OCID), .NUM_SRC(NS), .NUM_BANKS(NB), .DATA_W(DW),
        .REG_ID_W(RW), .TAG_W(TW), .PYLD_W(PW)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .alloc_vld(alloc_vld), .alloc_rdy(alloc_rdy),
        .alloc_src_mask(alloc_src_mask), .alloc_reg_id(alloc_reg_id), .alloc_pyld(alloc_pyld),
        .rq_vld(rq_vld), .rq_rdy(rq_rdy), .rq_reg_id(rq_reg_id), .rq_tag(rq_tag),
        .bk_vld(bk_vld), .bk_bz(bk_bz), .bk_tag(bk_tag), .bk_data(bk_data),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data), .out_pyld(out_pyld)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [NS*DW-1:0] obs, input logic [NS*DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic set_bank(input int b, input logic [TW-1:0] tag, input logic [DW-1:0] d, input logic bz);
        bk_vld[b]          = 1'b1;
        bk_bz[b]           = bz;
        bk_tag[b*TW +: TW] = tag;
        bk_data[b*DW +: DW] = d;
    endtask

    task automatic clear_banks();
        bk_vld  = '0;
        bk_bz   = '0;
        bk_tag  = '0;
        bk_data = '0;
    endtask

    initial begin
        d0 = 256'h0A0A_0000_1111; d1 = 256'h0B0B_0000_2222; d2 = 256'h0C0C_0000_3333;
        d3 = 256'h0D0D_0000_4444; d4 = 256'h0E0E_0000_5555; d5 = 256'h0F0F_0000_6666;
        d6 = 256'h1010_0000_7777; zero = '0;
        p1 = 64'hDEAD_BEEF_0123_4567; p2 = 64'h0000_CAFE_F00D_0042;
        rst = 1'b1; flush = 1'b0; alloc_vld = 1'b0; alloc_src_mask = '0;
        alloc_reg_id = '0; alloc_pyld = '0; rq_rdy = 1'b0; out_rdy = 1'b0;
        clear_banks();
        step(); step();
        rst = 1'b0;
        step();

        // Reset / idle
        check("rst_alloc_rdy", 768'(alloc_rdy), 768'(1));
        check("rst_out_vld",   768'(out_vld),   768'(0));
        check("rst_rq_vld",    768'(rq_vld),    768'(0));
        check("rst_out_data",  out_data,        768'(0));
        check("rst_out_pyld",  768'(out_pyld),  768'(0));

        // Flush in IDLE blocks allocation
        alloc_vld = 1'b1; alloc_src_mask = 3'b111; flush = 1'b1;
        alloc_reg_id = {5'd30, 5'd12, 5'd5}; alloc_pyld = p1;
        step();
        flush = 1'b0; alloc_vld = 1'b0;
        check("flush_idle_rdy", 768'(alloc_rdy), 768'(1));
        check("flush_idle_rq",  768'(rq_vld),    768'(0));

        // Full three-source allocation
        alloc_vld = 1'b1;
        step();
        alloc_vld = 1'b0;
        check("alloc_rdy_low", 768'(alloc_rdy), 768'(0));
        // Return for slot 0 before it is requested: must be ignored
        set_bank(0, 4'd3, d5, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("stall_rq_vld", 768'(rq_vld),    768'(1));
            check("stall_rq_reg", 768'(rq_reg_id), 768'(5));
            check("stall_rq_tag", 768'(rq_tag),    768'(3));
            step();
            clear_banks();
        end
        check("early_ret_ignored", out_data, 768'(0));
        rq_rdy = 1'b1;
        step();
        check("rq1_reg", 768'(rq_reg_id), 768'(12));
        check("rq1_tag", 768'(rq_tag),    768'(4));
        step();
        check("rq2_reg", 768'(rq_reg_id), 768'(30));
        check("rq2_tag", 768'(rq_tag),    768'(5));
        step();
        rq_rdy = 1'b0;
        check("rq_done", 768'(rq_vld), 768'(0));

        // Busy bank and wrong bank returns are ignored
        set_bank(3, 4'd5, d5, 1'b1);
        set_bank(2, 4'd5, d4, 1'b0);
        step();
        clear_banks();
        check("bz_wrongbank_ignored", out_data, 768'(0));
        set_bank(3, 4'd5, d2, 1'b0);
        step();
        clear_banks();
        check("cap_slot2", out_data, {d2, zero, zero});
        set_bank(1, 4'd4, d1, 1'b0);
        step();
        clear_banks();
        check("not_ready_yet", 768'(out_vld), 768'(0));
        set_bank(0, 4'd3, d0, 1'b0);
        step();
        clear_banks();
        check("out_vld_rise", 768'(out_vld),  768'(1));
        check("out_data_all", out_data,        {d2, d1, d0});
        check("out_pyld",     768'(out_pyld),  768'(p1));
        out_rdy = 1'b1;
        step();
        out_rdy = 1'b0;
        check("dispatch_idle", 768'(alloc_rdy), 768'(1));
        check("dispatch_vld",  768'(out_vld),   768'(0));
        check("dispatch_hold", out_data,        {d2, d1, d0});

        // Single needed source in slot 1
        alloc_vld = 1'b1; alloc_src_mask = 3'b010; alloc_pyld = p2;
        step();
        alloc_vld = 1'b0;
        check("m010_cleared", out_data,         768'(0));
        check("m010_rq_tag",  768'(rq_tag),     768'(4));
        check("m010_rq_reg",  768'(rq_reg_id),  768'(12));
        rq_rdy = 1'b1;
        step();
        rq_rdy = 1'b0;
        check("m010_one_rq", 768'(rq_vld), 768'(0));
        set_bank(1, 4'd4, d3, 1'b0);
        step();
        clear_banks();
        for (int i = 0; i < 3; i++) begin
            check("m010_hold_vld",  768'(out_vld),  768'(1));
            check("m010_hold_data", out_data,       {zero, d3, zero});
            check("m010_hold_pyld", 768'(out_pyld), 768'(p2));
            step();
        end
        out_rdy = 1'b1;
        step();
        out_rdy = 1'b0;

        // Empty mask goes straight to READY
        alloc_vld = 1'b1; alloc_src_mask = 3'b000;
        step();
        alloc_vld = 1'b0;
        check("m000_vld",  768'(out_vld), 768'(1));
        check("m000_data", out_data,      768'(0));
        out_rdy = 1'b1;
        step();
        out_rdy = 1'b0;

        // Flush mid-COLLECT after one capture
        alloc_vld = 1'b1; alloc_src_mask = 3'b111; alloc_pyld = p1;
        step();
        alloc_vld = 1'b0; rq_rdy = 1'b1;
        step(); step();
        rq_rdy = 1'b0;
        set_bank(0, 4'd3, d4, 1'b0);
        step();
        clear_banks();
        check("fl_cap0", out_data, {zero, zero, d4});
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("fl_rdy", 768'(alloc_rdy), 768'(1));
        check("fl_vld", 768'(out_vld),   768'(0));
        check("fl_rq",  768'(rq_vld),    768'(0));
        set_bank(1, 4'd4, d5, 1'b0);
        step();
        clear_banks();
        check("fl_stale_ignored", out_data, {zero, zero, d4});

        // New allocation after flush completes normally
        alloc_vld = 1'b1; alloc_src_mask = 3'b001;
        step();
        alloc_vld = 1'b0; rq_rdy = 1'b1;
        step();
        rq_rdy = 1'b0;
        set_bank(0, 4'd3, d6, 1'b0);
        step();
        clear_banks();
        check("post_fl_vld",  768'(out_vld), 768'(1));
        check("post_fl_data", out_data,      {zero, zero, d6});
        out_rdy = 1'b1;
        step();
        out_rdy = 1'b0;
        check("post_fl_idle", 768'(alloc_rdy), 768'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
